// File: rtl/row_pointer_update_n.sv
// row_pointer_update_n: per-channel row-number tracker for the routing grid
// walker. Each channel loads a start row from a packed row word (entry chosen
// by the low coordinate bits, entry 0 at the MSB end) and then steps that row
// on found/wire events, saturating at MAX_ROW.
// Optional build macro ROW_PTR_WRAP_EN: an advance at MAX_ROW wraps to 0 and
// reports a one-cycle row_sat strobe instead of saturating.
module row_pointer_update_n #(
  parameter int NUM_CH  = 2,
  parameter int ENTRIES = 16,
  parameter int ENTRY_W = 16,
  parameter int ROW_W   = 11,
  parameter int COORD_W = 16,
  parameter int MAX_ROW = 2047
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              enable,
  input  logic [NUM_CH*COORD_W-1:0]         coord,
  input  logic [NUM_CH*ENTRIES*ENTRY_W-1:0] row_word,
  input  logic [NUM_CH-1:0]                 flag,
  input  logic [NUM_CH-1:0]                 diag_done,
  input  logic [2*NUM_CH-1:0]               found,
  input  logic [NUM_CH-1:0]                 wire_hit,
  output logic [NUM_CH*ROW_W-1:0]           row_no,
  output logic [NUM_CH-1:0]                 row_valid,
  output logic [NUM_CH-1:0]                 row_sat,
  output logic [NUM_CH-1:0]                 adv_pulse
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_TRACK = 2'd1,
    ST_SAT   = 2'd2
  } state_t;

  localparam int IDX_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int WORD_W = ENTRIES * ENTRY_W;
  localparam logic [ROW_W-1:0] MAX_ROW_V = ROW_W'(MAX_ROW);

  // Only the low coordinate bits and the low entry bits are consumed; fold
  // the full inputs here so the partially used buses are accounted for.
  logic unused_in;
  assign unused_in = ^{coord, row_word};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic               sat_q, sat_d;
    logic               adv_q, adv_d;
    logic [WORD_W-1:0]  word;
    logic [IDX_W-1:0]   idx;
    logic [ROW_W-1:0]   ld_val;
    logic               ld_req;
    logic               adv_req;
    logic               ld_clamp;

    assign word     = row_word[c*WORD_W +: WORD_W];
    assign idx      = coord[c*COORD_W +: IDX_W];
    assign ld_req   = enable & flag[c] & ~diag_done[c];
    assign adv_req  = enable & diag_done[c] & ((found[2*c +: 2] == 2'b01) | wire_hit[c]);
    assign ld_clamp = (ld_val > MAX_ROW_V);

    // Entry mux: entry k lives at the (ENTRIES-1-k)-th slot from the LSB end.
    always_comb begin
      ld_val = '0;
      for (int k = 0; k < ENTRIES; k++) begin
        if (idx == IDX_W'(k)) begin
          ld_val = word[(ENTRIES-1-k)*ENTRY_W +: ROW_W];
        end
      end
    end

    // Channel FSM next-state: load has priority in form only (L and A never
    // coincide because of the diag_done term); enable=0 leaves everything held.
    always_comb begin
      state_d = state_q;
      row_d   = row_q;
      adv_d   = 1'b0;
`ifdef ROW_PTR_WRAP_EN
      sat_d   = 1'b0;
`else
      sat_d   = sat_q;
`endif
      if (ld_req) begin
        if (ld_clamp) begin
          row_d   = MAX_ROW_V;
          state_d = ST_SAT;
          sat_d   = 1'b1;
        end else begin
          row_d   = ld_val;
          state_d = ST_TRACK;
          sat_d   = 1'b0;
        end
      end else if (adv_req && (state_q == ST_TRACK)) begin
        if (row_q < MAX_ROW_V) begin
          row_d = row_q + ROW_W'(1);
          adv_d = 1'b1;
        end else begin
`ifdef ROW_PTR_WRAP_EN
          row_d = '0;
          adv_d = 1'b1;
          sat_d = 1'b1;
`else
          state_d = ST_SAT;
          sat_d   = 1'b1;
`endif
        end
      end
    end

    // Channel state registers; reset discards everything immediately.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= ST_EMPTY;
        row_q   <= '0;
        sat_q   <= 1'b0;
        adv_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        row_q   <= row_d;
        sat_q   <= sat_d;
        adv_q   <= adv_d;
      end
    end

    assign row_no[c*ROW_W +: ROW_W] = row_q;
    assign row_valid[c]             = (state_q != ST_EMPTY);
    assign row_sat[c]               = sat_q;
    assign adv_pulse[c]             = adv_q;
  end

endmodule

// File: tb/tb_row_pointer_update_n.sv
// Directed bench for row_pointer_update_n with a queue-based scoreboard.
module tb_row_pointer_update_n;
  localparam int NUM_CH  = 2;
  localparam int ENTRIES = 16;
  localparam int ENTRY_W = 16;
  localparam int ROW_W   = 11;
  localparam int COORD_W = 16;
  localparam int WORD_W  = ENTRIES * ENTRY_W;

  logic                              clock = 1'b0;
  logic                              reset_n = 1'b0;
  logic                              enable = 1'b0;
  logic [NUM_CH*COORD_W-1:0]         coord = '0;
  logic [NUM_CH*ENTRIES*ENTRY_W-1:0] row_word = '0;
  logic [NUM_CH-1:0]                 flag = '0;
  logic [NUM_CH-1:0]                 diag_done = '0;
  logic [2*NUM_CH-1:0]               found = '0;
  logic [NUM_CH-1:0]                 wire_hit = '0;
  logic [NUM_CH*ROW_W-1:0]           row_no;
  logic [NUM_CH-1:0]                 row_valid;
  logic [NUM_CH-1:0]                 row_sat;
  logic [NUM_CH-1:0]                 adv_pulse;

  row_pointer_update_n #(
    .NUM_CH(NUM_CH), .ENTRIES(ENTRIES), .ENTRY_W(ENTRY_W),
    .ROW_W(ROW_W), .COORD_W(COORD_W), .MAX_ROW(2047)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .coord(coord),
    .row_word(row_word), .flag(flag), .diag_done(diag_done), .found(found),
    .wire_hit(wire_hit), .row_no(row_no), .row_valid(row_valid),
    .row_sat(row_sat), .adv_pulse(adv_pulse)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0]      id;
    logic [ROW_W-1:0] r0;
    logic [ROW_W-1:0] r1;
    logic [1:0]       v;
    logic [1:0]       s;
    logic [1:0]       a;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic check_out(input exp_t e);
    string t;
    t = $sformatf("step%0d", e.id);
    cmp({t, " row_no0"},    32'(row_no[ROW_W-1:0]),     32'(e.r0));
    cmp({t, " row_no1"},    32'(row_no[2*ROW_W-1:ROW_W]), 32'(e.r1));
    cmp({t, " row_valid"},  32'(row_valid),              32'(e.v));
    cmp({t, " row_sat"},    32'(row_sat),                32'(e.s));
    cmp({t, " adv_pulse"},  32'(adv_pulse),              32'(e.a));
  endtask

  // Issue one clock of stimulus (inputs already set) and queue its expected result.
  task automatic expect_cycle(input logic [ROW_W-1:0] r0, input logic [ROW_W-1:0] r1,
                              input logic [1:0] v, input logic [1:0] s, input logic [1:0] a);
    exp_t e;
    step_id++;
    e.id = 16'(step_id); e.r0 = r0; e.r1 = r1; e.v = v; e.s = s; e.a = a;
    exp_q.push_back(e);
    @(negedge clock);
  endtask

  task automatic set_entry(input int c, input int k, input logic [ENTRY_W-1:0] val);
    row_word[c*WORD_W + (ENTRIES-1-k)*ENTRY_W +: ENTRY_W] = val;
  endtask

  // Monitor: after every rising edge, compare against the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_out(e);
      end
    end
  end

  initial begin
    exp_t zero;
    zero = '0;

    // Reset state
    #1;
    check_out(zero);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    enable  = 1'b1;

    // Advance while EMPTY is ignored on both channels
    diag_done = 2'b11; found = 4'b0101;
    expect_cycle(11'h000, 11'h000, 2'b00, 2'b00, 2'b00);

    // Load ch0 from entry 3
    diag_done = 2'b00; found = 4'b0000;
    coord[15:0] = 16'h0003;
    set_entry(0, 3, 16'h0123);
    flag = 2'b01;
    expect_cycle(11'h123, 11'h000, 2'b01, 2'b00, 2'b00);

    // Entry ordering on ch1: entry 15 at LSB end, entry 0 at MSB end
    flag = 2'b10;
    coord[31:16] = 16'h000F;
    set_entry(1, 15, 16'h07FF);
    set_entry(1, 0,  16'h0005);
    expect_cycle(11'h123, 11'h7FF, 2'b11, 2'b00, 2'b00);
    coord[31:16] = 16'h0010;
    expect_cycle(11'h123, 11'h005, 2'b11, 2'b00, 2'b00);

    // Advance ch0 three times on found==01
    flag = 2'b00; diag_done = 2'b01; found = 4'b0001;
    expect_cycle(11'h124, 11'h005, 2'b11, 2'b00, 2'b01);
    expect_cycle(11'h125, 11'h005, 2'b11, 2'b00, 2'b01);
    expect_cycle(11'h126, 11'h005, 2'b11, 2'b00, 2'b01);

    // found==10 is not a hit
    found = 4'b0010;
    expect_cycle(11'h126, 11'h005, 2'b11, 2'b00, 2'b00);

    // wire_hit alone advances
    found = 4'b0000; wire_hit = 2'b01;
    expect_cycle(11'h127, 11'h005, 2'b11, 2'b00, 2'b01);

    // Load near the top of the range, then advance past it
    wire_hit = 2'b00; diag_done = 2'b00; flag = 2'b01;
    set_entry(0, 3, 16'h07FE);
    expect_cycle(11'h7FE, 11'h005, 2'b11, 2'b00, 2'b00);
    flag = 2'b00; diag_done = 2'b01; found = 4'b0001;
    expect_cycle(11'h7FF, 11'h005, 2'b11, 2'b00, 2'b01);
`ifdef ROW_PTR_WRAP_EN
    expect_cycle(11'h000, 11'h005, 2'b11, 2'b01, 2'b01);
    expect_cycle(11'h001, 11'h005, 2'b11, 2'b00, 2'b01);
`else
    expect_cycle(11'h7FF, 11'h005, 2'b11, 2'b01, 2'b00);
    expect_cycle(11'h7FF, 11'h005, 2'b11, 2'b01, 2'b00);
`endif

    // enable=0: ch1 load and ch0 advance both blocked, status held
    enable = 1'b0; flag = 2'b10;
    set_entry(1, 0, 16'h0222);
`ifdef ROW_PTR_WRAP_EN
    expect_cycle(11'h001, 11'h005, 2'b11, 2'b00, 2'b00);
`else
    expect_cycle(11'h7FF, 11'h005, 2'b11, 2'b01, 2'b00);
`endif

    // Simultaneous: ch0 reload, ch1 advance
    enable = 1'b1; flag = 2'b01; diag_done = 2'b10; found = 4'b0100;
    set_entry(0, 3, 16'h0100);
    expect_cycle(11'h100, 11'h006, 2'b11, 2'b00, 2'b10);

    // ch0 advancing, then async reset between edges
    flag = 2'b00; diag_done = 2'b01; found = 4'b0001;
    expect_cycle(11'h101, 11'h006, 2'b11, 2'b00, 2'b01);
    #2;
    reset_n = 1'b0;
    #1;
    check_out(zero);
    @(negedge clock);
    check_out(zero);

    // Release and load again from reset state
    reset_n = 1'b1;
    diag_done = 2'b00; found = 4'b0000; flag = 2'b01;
    expect_cycle(11'h100, 11'h000, 2'b01, 2'b00, 2'b00);
    flag = 2'b00;

    // Drain: the monitor must have consumed every expectation
    @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the bench always terminates
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete, expected finish before 20000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/row_pointer_update_n.md
Name: row_pointer_update_n

Overview:
- Per-channel row-number tracker for the routing grid walker. Parametrised, N-channel generalisation of the two-channel (X/Y) row-update logic.
- Load: each channel extracts a start row number from a packed row word, indexed by the low bits of its coordinate.
- Advance: each channel then steps the row on found/wire events.
- Adds to the older logic: reset, a per-channel FSM, valid/saturation status and an advance strobe.

Parameters:
- NUM_CH, 2, number of independent channels (X=0, Y=1 in the current floorplan)
- ENTRIES, 16, entries per packed row word; power of two, >=2
- ENTRY_W, 16, width of one entry in the row word
- ROW_W, 11, row-number width; ROW_W <= ENTRY_W
- COORD_W, 16, coordinate width; COORD_W >= log2(ENTRIES)
- MAX_ROW, 2047, highest legal row number; MAX_ROW <= 2^ROW_W-1

Ports:
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  global update enable; when 0 all channel state holds
- coord  in  NUM_CH*COORD_W  per-channel coordinate; channel c at [c*COORD_W +: COORD_W]
- row_word  in  NUM_CH*ENTRIES*ENTRY_W  per-channel packed row word; channel c at [c*ENTRIES*ENTRY_W +: ENTRIES*ENTRY_W]
- flag  in  NUM_CH  load request per channel
- diag_done  in  NUM_CH  diagonal phase complete per channel
- found  in  2*NUM_CH  2-bit found code per channel; 2'b01 = hit
- wire_hit  in  NUM_CH  wire-present advance request per channel
- row_no  out  NUM_CH*ROW_W  current row number per channel
- row_valid  out  NUM_CH  row_no holds a loaded value
- row_sat  out  NUM_CH  saturation/wrap status, see Optional Feature
- adv_pulse  out  NUM_CH  1-cycle strobe, coincident with each row_no increment

Behaviour:
- Reset (async assert, sync release):
  - row_no=0, row_valid=0, row_sat=0, adv_pulse=0.
  - Every channel FSM goes to EMPTY.
  - Reset asserted mid-operation discards all state immediately.
- Entry select: idx = coord_c[log2(ENTRIES)-1:0].
  - Entry k sits at bits [(ENTRIES-1-k)*ENTRY_W +: ENTRY_W] of the channel word, so entry 0 is at the MSB end.
  - The loaded value is the low ROW_W bits of that entry.
- Load condition L_c = enable & flag_c & ~diag_done_c.
- Advance condition A_c = enable & diag_done_c & (found_c==2'b01 | wire_hit_c).
  - L and A are mutually exclusive by construction (diag_done term).
- All updates are registered; row_no/status change on the clock edge following the qualifying inputs, i.e. 1-cycle latency.
- Per-channel FSM:
  - EMPTY: L -> TRACK, load row_no, row_valid=1. A ignored (no increment, no adv_pulse).
  - TRACK:
    - L -> reload, stay TRACK.
    - A with row_no<MAX_ROW -> row_no+1, adv_pulse=1.
    - A with row_no==MAX_ROW -> SAT; row_no holds; row_sat=1; no adv_pulse.
  - SAT: A ignored; L -> reload, row_sat=0, -> TRACK.
- Loaded value > MAX_ROW: row_no clamped to MAX_ROW, state SAT, row_sat=1.
- adv_pulse is high for exactly one cycle per increment and is deasserted every other cycle.
- enable=0: no loads, no advances, adv_pulse=0; row_no/row_valid/row_sat hold.
- Channels are fully independent; simultaneous events on different channels all take effect in the same cycle.

Optional Feature:
- Macro ROW_PTR_WRAP_EN.
- Defined:
  - A in TRACK at row_no==MAX_ROW sets row_no=0, asserts adv_pulse=1 and row_sat=1 for that one cycle only (wrap strobe), and stays in TRACK.
  - SAT is unreachable except via a clamped load; a clamped load is still reported by a 1-cycle row_sat.
- Undefined: saturating behaviour as above, with row_sat sticky until the next load.

Test Plan:
- Reset then load: reset_n 0->1; ch0 coord=0x0003, flag0=1, diag_done0=0, word entry3=0x0123 -> next cycle row_no0=0x123, row_valid0=1, row_sat0=0; ch1 unchanged at 0/valid 0.
- Entry ordering: ch1 coord=0x000F, entry15 (bits [15:0])=0x07FF, entry0 (bits [255:240])=0x0005, load -> row_no1=0x7FF; repeat with coord=0x0010 -> row_no1=0x005.
- Advance: ch0 at 0x123, diag_done0=1, found0=2'b01 for 3 cycles -> row_no0=0x124,0x125,0x126 with adv_pulse0 high each cycle; then found0=2'b10, wire_hit0=0 -> row_no0 holds, adv_pulse0=0.
- Saturation/wrap: load 0x7FE, advance 3 times -> default: 0x7FF, then row_sat0=1, row_no0 holds 0x7FF, one adv_pulse total; with ROW_PTR_WRAP_EN: 0x7FF, 0x000 with row_sat0 pulse, 0x001.
- Gating: advance while EMPTY -> row_no0=0, no adv_pulse; enable=0 with flag1=1 -> no load; simultaneous load ch0 and advance ch1 -> both updated same cycle.
- Async reset mid-advance: assert reset_n low between clock edges during advances -> all outputs 0 immediately, without waiting for a clock edge.
